// File: rtl/alu_pkg.sv
// Shared constants and types for the nibble-serial ALU front end and its 4-bit slice.
package alu_pkg;

    localparam int unsigned NIBBLES   = 4;
    localparam int unsigned NIB_W     = 4;
    localparam int unsigned NIB_CNT_W = $clog2(NIBBLES);

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/FourBitALU.sv
// 4-bit ALU slice: AND/OR/ADD/SUB/SLT with carry chaining, group G/P, set and overflow.
module FourBitALU
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       less,
    input  logic [2:0] op,
    output logic [3:0] result,
    output logic       cout,
    output logic       G,
    output logic       P,
    output logic       set,
    output logic       overflow,
    output logic       zero
);

    logic [3:0] bb;
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] sum;
    logic       c3;

    // op[2] selects inverted B so SUB/SLT compute a + ~b + cin
    always_comb begin
        bb            = op[2] ? ~b : b;
        g             = a & bb;
        p             = a | bb;
        {cout, sum}   = 5'({1'b0, a}) + 5'({1'b0, bb}) + 5'({4'b0, cin});
        c3            = a[3] ^ bb[3] ^ sum[3];
        overflow      = c3 ^ cout;
        set           = sum[3];
        G             = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        P             = &p;
        unique case (op[1:0])
            2'b00:   result = a & bb;
            2'b01:   result = a | bb;
            2'b10:   result = sum;
            default: result = {3'b000, less};
        endcase
        zero          = (result == 4'h0);
    end

endmodule

// File: rtl/nibble_serial_alu.sv
// 16-bit ALU built by stepping one 4-bit slice over four nibbles, LSB first, with a
// registered carry between steps; result and flags are presented with a one-cycle done pulse.
module nibble_serial_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam logic [NIB_CNT_W-1:0] LAST_NIB = NIB_CNT_W'(NIBBLES - 1);

    state_t               state;
    state_t               state_next;
    logic [NIB_CNT_W-1:0] nib;
    logic                 carry;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2:0]           op_q;

    logic [NIB_W-1:0]     slice_a;
    logic [NIB_W-1:0]     slice_b;
    logic                 slice_cin;
    logic [NIB_W-1:0]     slice_result;
    logic                 slice_cout;
    logic                 slice_set;
    logic                 slice_ovf;
    logic                 slice_g_unused;
    logic                 slice_p_unused;
    logic                 slice_zero_unused;

    logic [WIDTH-1:0]     final_result;
    logic                 final_cout;
    logic                 final_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (nib == LAST_NIB) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        slice_a   = a_q[{nib, 2'b00} +: NIB_W];
        slice_b   = b_q[{nib, 2'b00} +: NIB_W];
        slice_cin = (nib == '0) ? op_q[2] : carry;
    end

    FourBitALU u_slice (
        .a        (slice_a),
        .b        (slice_b),
        .cin      (slice_cin),
        .less     (1'b0),
        .op       (op_q),
        .result   (slice_result),
        .cout     (slice_cout),
        .G        (slice_g_unused),
        .P        (slice_p_unused),
        .set      (slice_set),
        .overflow (slice_ovf),
        .zero     (slice_zero_unused)
    );

    // Final values assembled on the last nibble so they are valid in the DONE cycle
    always_comb begin
        final_result = {slice_result, result[WIDTH-NIB_W-1:0]};
        final_cout   = 1'b0;
        final_ovf    = 1'b0;
        unique case (op_q)
            ALU_AND, ALU_OR: ;
            ALU_ADD, ALU_SUB: begin
                final_cout = slice_cout;
                final_ovf  = slice_ovf;
            end
            ALU_SLT: begin
                final_result = WIDTH'(slice_set ^ slice_ovf);
                final_cout   = slice_cout;
                final_ovf    = slice_ovf;
            end
            default: final_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nib      <= '0;
            carry    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b1;
        end else begin
            busy <= (state_next != S_IDLE);
            done <= (state_next == S_DONE);
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q  <= a;
                        b_q  <= b;
                        op_q <= op;
                        nib  <= '0;
                    end
                end
                S_RUN: begin
                    carry <= slice_cout;
                    nib   <= nib + NIB_CNT_W'(1);
                    if (nib == LAST_NIB) begin
                        result   <= final_result;
                        cout     <= final_cout;
                        overflow <= final_ovf;
                        zero     <= (final_result == '0);
                    end else begin
                        result[{nib, 2'b00} +: NIB_W] <= slice_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/nibble_serial_alu.md
# nibble_serial_alu

Multi-cycle 16-bit ALU front end that drives the existing 4-bit ALU slice one nibble per clock, least-significant first, chaining carry between nibbles. It accepts a start/operand handshake, sequences four slice evaluations, collects result and flags, and presents a registered 16-bit result with a one-cycle done pulse. It sits between the datapath control and the slice, acting as the initiator and driver of every slice input.

## Interface
- `WIDTH`, default 16: operand width; fixed at 16, four nibbles.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `start` input 1: request; sampled only in IDLE.
- `op` input 3: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `a` input 16: operand A, captured on accepted start.
- `b` input 16: operand B, captured on accepted start.
- `busy` output 1: high from the cycle after accept through DONE.
- `done` output 1: one-cycle pulse when the result is valid.
- `result` output 16: final result, held until the next accepted start.
- `cout` output 1: carry out of nibble 3.
- `overflow` output 1: signed overflow of nibble 3 for ADD/SUB/SLT, else 0.
- `zero` output 1: `result == 16'h0000`.

## Operation
- FSM states: IDLE, RUN, DONE. `nib` is a 2-bit counter.
- IDLE: if `start`=1, capture `a`, `b`, `op`, set `nib`=0, and go to RUN. Otherwise hold all outputs.
- RUN: the slice receives nibble `nib` of each operand, `op`, and `less`=0.
  - Slice `cin` on nibble 0 is 1 for SUB/SLT (op[2]=1), else 0.
  - Slice `cin` on nibbles 1–3 is the registered `cout` of the previous nibble.
  - Each cycle, the slice result is written into `result[4*nib+3:4*nib]`.
  - When `nib`=3, latch `cout` and `overflow` from the slice and go to DONE. Otherwise increment `nib`.
- DONE: `done`=1 for exactly one cycle, then return to IDLE.
  - SLT: replace `result` with `{15'b0, set3 ^ ovf3}`, where `set3` and `ovf3` are the slice `set` and `overflow` from nibble 3.
  - `zero` is computed from the final `result`.
- AND/OR: `cout` and `overflow` are forced to 0.
- Illegal op (011, 100, 101): still takes 5 cycles. `result`=0x0000, `cout`=0, `overflow`=0, `zero`=1.
- `start` while `busy`=1 is ignored. No queueing occurs and the captured operands are unaffected.
- Arithmetic wraps modulo 2^16. No saturation.

## Timing
- Reset (`rst_n`=0 at a clk edge) sets:
  - state IDLE, `nib`=0
  - `busy`=0, `done`=0
  - `result`=0x0000, `cout`=0, `overflow`=0, `zero`=1
- Reset mid-operation aborts immediately with the same values. No done pulse follows.
- If `start` is sampled at edge T:
  - `busy`=1 from T+1.
  - RUN occupies cycles T+1..T+4, nibbles 0..3.
  - DONE occupies cycle T+5, with `done`=1 and final outputs valid.
  - `busy`=0 and IDLE from T+6.
- `start` asserted during the DONE cycle is ignored. The earliest next accept is T+6, so back-to-back throughput is one operation per 6 cycles.
- `result`, `cout`, `overflow` and `zero` are registered.
  - During RUN, partial nibbles are visible in `result` and are not valid.
  - Consumers use only `done` or the held value after it.
- The slice path is combinational inside one cycle: captured operand mux → slice → result register.

## Structure
- Shared package `alu_pkg`:
  - op constants `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`
  - state encoding constants `S_IDLE`, `S_RUN`, `S_DONE`
  - `NIBBLES`=4
- Sub-module: one instance of the existing `FourBitALU` slice, port order (a, b, cin, less, op, result, cout, G, P, set, overflow, zero).
  - `G`, `P` and the slice `zero` are left unused.
- Remaining logic is the FSM, nibble counter, carry register, operand and result registers, and the SLT/illegal-op fix-up.

## Test plan
- ADD 0x0001 + 0x0001, start at T: `done`=1 only at T+5 → `result`=0x0002, `cout`=0, `overflow`=0, `zero`=0; `busy`=1 on T+1..T+5.
- SUB 0x0004 − 0x0001 → 0x0003, `cout`=1, `overflow`=0. SUB 0x0005 − 0x0005 → 0x0000, `zero`=1, `cout`=1.
- ADD 0x7FFF + 0x0001 → 0x8000, `overflow`=1, `cout`=0. ADD 0xFFFF + 0x0001 → 0x0000, `cout`=1, `zero`=1, `overflow`=0.
- SLT 0xFFFF vs 0x0001 → 0x0001. SLT 0x7FFF vs 0x8000 → 0x0000 (overflow-corrected). AND 0xF0F0 & 0x3C3C → 0x3030, `cout`=0.
- `start` pulsed at T+2 and T+5 with new operands during an ADD → original result unaffected, single `done`. `rst_n`=0 at T+3 → `busy`=0, `result`=0x0000, no `done`.
- Illegal op 3'b101 → `done` at T+5, `result`=0x0000, `zero`=1, `cout`=0, `overflow`=0.
